// File: rtl/cpu_decode_pkg.sv
// Shared definitions for the MIPS decode stage.
// Holds the opcode and REGIMM selector values, the instruction-format and FSM
// state enums, and the pure decode functions used by cpu_decode_stage:
//   decode_type()     - opcode -> R/I/J format (OP_NONE for unknown opcodes)
//   decode_dest()     - instruction -> destination register (0 = no write)
//   decode_operand2() - instruction/PC/rt data -> second operand
// The decode functions work on 32-bit MIPS words and 5-bit register indices.
package cpu_decode_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_REGIMM  = 6'b000001;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_BLEZ    = 6'b000110;
  localparam logic [5:0] OPC_BGTZ    = 6'b000111;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_SLTI    = 6'b001010;
  localparam logic [5:0] OPC_SLTIU   = 6'b001011;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LB      = 6'b100000;
  localparam logic [5:0] OPC_LH      = 6'b100001;
  localparam logic [5:0] OPC_LWL     = 6'b100010;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_LBU     = 6'b100100;
  localparam logic [5:0] OPC_LHU     = 6'b100101;
  localparam logic [5:0] OPC_LWR     = 6'b100110;
  localparam logic [5:0] OPC_SB      = 6'b101000;
  localparam logic [5:0] OPC_SH      = 6'b101001;
  localparam logic [5:0] OPC_SWL     = 6'b101010;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_SWR     = 6'b101110;

  // REGIMM rt selectors that write the link register
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {OP_R, OP_I, OP_J, OP_NONE} op_type_e;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_HOLD} state_e;

  function automatic op_type_e decode_type(input logic [5:0] opc);
    op_type_e t;
    case (opc)
      OPC_SPECIAL:                                   t = OP_R;
      OPC_J, OPC_JAL:                                t = OP_J;
      OPC_REGIMM, OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ,
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
      OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI,
      OPC_LB, OPC_LH, OPC_LWL, OPC_LW, OPC_LBU, OPC_LHU, OPC_LWR,
      OPC_SB, OPC_SH, OPC_SWL, OPC_SW, OPC_SWR:      t = OP_I;
      default:                                       t = OP_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [4:0] decode_dest(input logic [31:0] instr,
                                             input logic [4:0]  link_reg);
    logic [4:0] dest;
    dest = '0;
    case (instr[31:26])
      OPC_SPECIAL: dest = instr[15:11];
      OPC_JAL:     dest = link_reg;
      OPC_REGIMM:  dest = (instr[20:16] == RT_BLTZAL || instr[20:16] == RT_BGEZAL) ? link_reg : '0;
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
      OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI,
      OPC_LB, OPC_LH, OPC_LWL, OPC_LW, OPC_LBU, OPC_LHU, OPC_LWR:
                   dest = instr[20:16];
      default:     dest = '0;
    endcase
    return dest;
  endfunction

  function automatic logic [31:0] decode_operand2(input logic [31:0] instr,
                                                  input logic [31:0] addr,
                                                  input logic [31:0] rt_data);
    logic signed [15:0] imm_s;
    logic signed [31:0] imm_sext;
    logic [31:0]        pc_next;
    logic [31:0]        op2;
    imm_s    = instr[15:0];
    imm_sext = 32'(imm_s);
    pc_next  = addr + 32'd4;
    case (instr[31:26])
      OPC_SPECIAL, OPC_BEQ, OPC_BNE: op2 = rt_data;
      OPC_ANDI, OPC_ORI, OPC_XORI:   op2 = {16'h0000, instr[15:0]};
      OPC_LUI:                       op2 = {instr[15:0], 16'h0000};
      OPC_J, OPC_JAL:                op2 = {pc_next[31:28], instr[25:0], 2'b00};
      default:                       op2 = (decode_type(instr[31:26]) == OP_I) ? imm_sext : '0;
    endcase
    return op2;
  endfunction

endpackage

// File: rtl/cpu_decode_queue.sv
// Synchronous FIFO feeding the decode stage.
// Ports: clock/reset (sync, active-high); push/push_data write an entry when
// not full; pop removes the head when not empty; head_data shows the oldest
// entry combinationally; empty is decoded from the count; full is registered
// and reflects the post-edge count reaching DEPTH.
module cpu_decode_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  import cpu_decode_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
      full  <= (count_next == CNT_FULL);
    end
  end

  // Storage carries data only; pointers/count decide what is live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu_decode_stage.sv
// MIPS decode stage between the fetch and execute FIFOs.
// Ports:
//   clock, reset          - single rising-edge clock, sync active-high reset
//   reg_s, reg_t          - register-file read addresses (rs, rt of queue head)
//   reg_id_d              - destination the scoreboard claims (0 = none)
//   reg_s_data/reg_t_data - same-cycle register-file read data
//   reg_stall             - read operands have a pending write
//   input_*               - instruction offer from fetch (valid / registered full)
//   output_*              - decoded entry to execute (valid / full handshake)
// Unknown opcodes are issued as a NOP (instruction word 0, no destination).
module cpu_decode_stage
  import cpu_decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int IN_DEPTH = 2,
  parameter int LINK_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  output logic [REG_AW-1:0] reg_s,
  output logic [REG_AW-1:0] reg_t,
  output logic [REG_AW-1:0] reg_id_d,
  input  logic [DATA_W-1:0] reg_s_data,
  input  logic [DATA_W-1:0] reg_t_data,
  input  logic              reg_stall,
  input  logic [DATA_W-1:0] input_address,
  input  logic [DATA_W-1:0] input_instruction,
  input  logic              input_valid,
  output logic              input_full,
  output logic [DATA_W-1:0] output_operand1,
  output logic [DATA_W-1:0] output_operand2,
  output logic [REG_AW-1:0] output_writereg,
  output logic [DATA_W-1:0] output_instruction,
  output logic [DATA_W-1:0] output_address,
  output logic              output_valid,
  input  logic              output_full
);

  state_e              state;
  state_e              state_next;
  logic                q_push;
  logic                q_pop;
  logic                q_empty;
  logic [2*DATA_W-1:0] q_head;
  logic [DATA_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_instr;
  logic [REG_AW-1:0]   head_dest;
  logic [DATA_W-1:0]   head_op2;
  logic                head_known;
  logic                accept;
  logic                load_addr;
  logic                load_out;
  logic                clear_valid;

  // Input queue: entries are {address, instruction}
  assign q_push = input_valid && !input_full;

  cpu_decode_queue #(
    .WIDTH(2 * DATA_W),
    .DEPTH(IN_DEPTH)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .push     (q_push),
    .push_data({input_address, input_instruction}),
    .pop      (q_pop),
    .head_data(q_head),
    .empty    (q_empty),
    .full     (input_full)
  );

  assign {head_addr, head_instr} = q_head;

  // Decode of the queue head; operands come from the regfile in the same cycle
  assign head_dest  = decode_dest(head_instr, REG_AW'(LINK_REG));
  assign head_op2   = decode_operand2(head_instr, head_addr, reg_t_data);
  assign head_known = (decode_type(head_instr[31:26]) != OP_NONE);
  assign accept     = output_valid && !output_full;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_addr   = 1'b0;
    load_out    = 1'b0;
    clear_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          state_next = ST_READ;
          load_addr  = 1'b1;
        end
      end
      ST_READ: begin
        // Stalled reads keep the addresses up and simply retry next cycle.
        if (!reg_stall) begin
          state_next = ST_HOLD;
          load_out   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          clear_valid = 1'b1;
          if (!q_empty) begin
            state_next = ST_READ;
            load_addr  = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign q_pop = load_out;

  // Read-address stage -> output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_s              <= '0;
      reg_t              <= '0;
      reg_id_d           <= '0;
      output_operand1    <= '0;
      output_operand2    <= '0;
      output_writereg    <= '0;
      output_instruction <= '0;
      output_address     <= '0;
      output_valid       <= 1'b0;
    end else begin
      if (load_addr) begin
        reg_s    <= head_instr[25:21];
        reg_t    <= head_instr[20:16];
        reg_id_d <= head_dest;
      end
      if (load_out) begin
        output_operand1    <= reg_s_data;
        output_operand2    <= head_op2;
        output_writereg    <= head_dest;
        output_instruction <= head_known ? head_instr : '0;
        output_address     <= head_addr;
        output_valid       <= 1'b1;
      end else if (clear_valid) begin
        output_valid <= 1'b0;
      end
    end
  end

endmodule
